// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 types, constants and unit state encodings for the FPU
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_seq_state_t;

endpackage

// File: rtl/fdiv_round.sv
// fdiv_round: normalize a 26-bit quotient, round to nearest even, flush on overflow/underflow
module fdiv_round
    import fpu_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  ex,
    input  logic        [25:0] q,
    input  logic               sticky,
    output logic        [31:0] y
);

    logic signed [9:0] e_n, e_r;
    logic [22:0]       man;
    logic              g, s, inc;
    logic [23:0]       sum;

    // quotient lies in (0.5, 2): pick the leading bit, round, then clamp the exponent range
    always_comb begin
        e_n = q[25] ? ex : ex - 10'sd1;
        man = q[25] ? q[24:2] : q[23:1];
        g   = q[25] ? q[1] : q[0];
        s   = q[25] ? (q[0] | sticky) : sticky;
        inc = g & (s | man[0]);
        sum = {1'b0, man} + 24'(inc);
        e_r = sum[23] ? e_n + 10'sd1 : e_n;
        y   = (e_r >= EXP_MAX) ? {sign, 8'hFF, 23'd0} :
              (e_r <= 0)       ? {sign, 31'd0} :
                                 {sign, e_r[7:0], sum[22:0]};
    end

endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative binary32 divider y = x1 / x2 with valid/ready handshakes
// Build option: define FDIV_SEQ_FLAGS_EN to add the {nv,dz,ovf,unf} flags port.
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int ITER_PER_CYC = 1
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
`ifdef FDIV_SEQ_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    if (ITER_PER_CYC != 1 && ITER_PER_CYC != 2) begin : g_bad_iter
        $error("fdiv_seq: ITER_PER_CYC must be 1 or 2");
    end

    localparam logic [4:0] QBITS = 5'd26;

    float_t            a, b;
    logic              s;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic              special, sp_nv;
    logic [31:0]       sp_y;
    fdiv_seq_state_t   state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       m2_q, m2_d;
    logic [25:0]       rem_q, rem_d, quo_q, quo_d, rem_nx, quo_nx;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       y_q, y_d, rnd_y;

    assign a         = x1;
    assign b         = x2;
    assign s         = a.sign ^ b.sign;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

    // classify operands; specials bypass the iteration and finish straight from IDLE
    always_comb begin
        a_zero  = (a.exp == 8'd0);
        b_zero  = (b.exp == 8'd0);
        a_inf   = (&a.exp) && (a.man == 23'd0);
        b_inf   = (&b.exp) && (b.man == 23'd0);
        a_nan   = (&a.exp) && (|a.man);
        b_nan   = (&b.exp) && (|b.man);
        special = a_zero | b_zero | (&a.exp) | (&b.exp);
        sp_nv   = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        sp_y    = sp_nv ? QNAN : (a_inf | b_zero) ? {s, 8'hFF, 23'd0} : {s, 31'd0};
    end

    // restoring division: ITER_PER_CYC quotient bits per cycle, remainder kept pre-shifted
    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        for (int i = 0; i < ITER_PER_CYC; i++) begin
            quo_nx = {quo_nx[24:0], rem_nx >= {2'b00, m2_q}};
            rem_nx = quo_nx[0] ? rem_nx - {2'b00, m2_q} : rem_nx;
            rem_nx = rem_nx << 1;
        end
    end

    fdiv_round u_round (
        .sign   (sign_q),
        .ex     (exp_q),
        .q      (quo_q),
        .sticky (|rem_q),
        .y      (rnd_y)
    );

    // next-state and datapath loads
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        m2_d    = m2_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = s;
                if (special) begin
                    y_d     = sp_y;
                    state_d = DONE;
                end else begin
                    exp_d   = 10'({2'b00, a.exp}) - 10'({2'b00, b.exp}) + 10'(EXP_BIAS);
                    m2_d    = {1'b1, b.man};
                    rem_d   = {3'b001, a.man};
                    quo_d   = 26'd0;
                    cnt_d   = 5'd0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                cnt_d   = cnt_q + 5'(ITER_PER_CYC);
                state_d = (cnt_d == QBITS) ? ROUND : DIV;
            end
            ROUND: begin
                y_d     = rnd_y;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            m2_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            m2_q    <= m2_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

`ifdef FDIV_SEQ_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       sp_dz;

    assign sp_dz = b_zero & ~a_inf & ~sp_nv;
    assign flags = flags_q;

    // flags load together with y and clear when a normal operation is accepted
    always_comb begin
        flags_d = flags_q;
        if (state_q == IDLE && in_valid)
            flags_d = special ? {sp_nv, sp_dz, 2'b00} : 4'b0000;
        else if (state_q == ROUND)
            flags_d = {2'b00, &rnd_y[30:23], ~|rnd_y[30:23]};
    end

    // flags register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: randomized and directed check of fdiv_seq against a real-arithmetic reference
module tb_fdiv_seq #(
    parameter int ITER = 1
);

    localparam int LAT = 26 / ITER + 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1, x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [3:0]  flags_w;
    int          total = 0;
    int          bad = 0;

    fdiv_seq #(.ITER_PER_CYC(ITER)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef FDIV_SEQ_FLAGS_EN
        ,
        .flags     (flags_w)
`endif
    );

`ifndef FDIV_SEQ_FLAGS_EN
    assign flags_w = 4'b0000;
`endif

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] v);
        logic [10:0] de;
        de = 11'(int'(v[30:23]) + 896);
        return $bitstoreal({v[31], de, v[22:0], 29'd0});
    endfunction

    // reference: exact IEEE double quotient re-rounded to 24 bits (innocuous for division), then range rules
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s, az, bz, ai, bi, an, bn;
        logic [63:0] bits;
        logic [52:0] mant;
        logic [24:0] m24;
        int          ex;
        s  = a[31] ^ b[31];
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
        ai = a[30:23] == 8'hFF && a[22:0] == 23'd0;
        bi = b[30:23] == 8'hFF && b[22:0] == 23'd0;
        an = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        bn = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        if (an || bn || (az && bz) || (ai && bi)) return {4'b1000, 32'h7FC00000};
        if (ai) return {4'b0000, s, 8'hFF, 23'd0};
        if (bz) return {4'b0100, s, 8'hFF, 23'd0};
        if (az || bi) return {4'b0000, s, 31'd0};
        bits = $realtobits(to_real(a) / to_real(b));
        ex   = int'(bits[62:52]) - 1023 + 127;
        mant = {1'b1, bits[51:0]};
        m24  = {1'b0, mant[52:29]};
        if (mant[28] && ((|mant[27:0]) || m24[0])) m24 = m24 + 25'd1;
        if (m24[24]) begin
            m24 = m24 >> 1;
            ex++;
        end
        if (ex >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (ex <= 0) return {4'b0001, s, 31'd0};
        return {4'b0000, s, 8'(ex), m24[22:0]};
    endfunction

    // one transaction from IDLE; lat counts edges from the accept edge (inclusive) to out_valid
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ry, output logic [3:0] rf, output int lat);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ry = y;
        rf = flags_w;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] dx1 [7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hC0800000,
                             32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] dx2 [7] = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000,
                             32'h00000000, 32'h3E800000, 32'h41000000};
    logic [31:0] dy  [7] = '{32'h40000000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
                             32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [3:0]  df  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
    int          dl  [7] = '{LAT, LAT, LAT, 1, 1, LAT, LAT};

    initial begin
        logic [31:0] ry, yb, ra, rb;
        logic [3:0]  rf;
        logic [35:0] ex;
        int          lat, n;
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x1 = '0;
        x2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset y", 64'(y), 64'd0);
`ifdef FDIV_SEQ_FLAGS_EN
        check("reset flags", 64'(flags_w), 64'd0);
`endif
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run(dx1[i], dx2[i], ry, rf, lat);
            check($sformatf("dir%0d y", i), 64'(ry), 64'(dy[i]));
            check($sformatf("dir%0d latency", i), 64'(lat), 64'(dl[i]));
`ifdef FDIV_SEQ_FLAGS_EN
            check($sformatf("dir%0d flags", i), 64'(rf), 64'(df[i]));
`endif
        end

        out_ready = 1'b0;
        run(32'h40C00000, 32'h40400000, yb, rf, lat);
        check("bp y", 64'(yb), 64'h40000000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp hold y", 64'(y), 64'(yb));
            check("bp hold in_ready", 64'(in_ready), 64'd0);
            check("bp hold out_valid", 64'(out_valid), 64'd1);
        end
        x1 = 32'h3F800000;
        x2 = 32'h3F800000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp release out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp next accepted", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp next y", 64'(y), 64'h3F800000);
        check("bp next latency", 64'(lat), 64'(LAT));
        @(posedge clk);
        #1;

        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst y", 64'(y), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            n += int'(out_valid);
        end
        check("midrst no output", 64'(n), 64'd0);
        run(32'h40C00000, 32'h40400000, ry, rf, lat);
        check("midrst next y", 64'(ry), 64'h40000000);
        check("midrst next latency", 64'(lat), 64'(LAT));

        for (int i = 0; i < 500; i++) begin
            ra = {1'(($urandom)), (i % 4 == 0) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154)),
                  23'($urandom)};
            rb = {1'(($urandom)), (i % 4 == 1) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(100, 154)),
                  23'($urandom)};
            ex = ref_div(ra, rb);
            run(ra, rb, ry, rf, lat);
            check($sformatf("rand %h/%h y", ra, rb), 64'(ry), 64'(ex[31:0]));
            check($sformatf("rand %h/%h latency", ra, rb), 64'(lat), 64'(LAT));
`ifdef FDIV_SEQ_FLAGS_EN
            check($sformatf("rand %h/%h flags", ra, rb), 64'(rf), 64'(ex[35:32]));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
